// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped 8N1 UART transmitter with TX FIFO
module uart_tx_periph #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DIV_DEFAULT = 16'd103
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic [15:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [15:0] OFF_DATA   = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0004;
  localparam logic [15:0] OFF_DIV    = 16'h0008;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic [15:0]   div_q, div_l_q;
  logic [15:0]   bcnt_q, bcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shift_q;
  logic          tx_q, tx_d;
  logic [31:0]   rd_data_q;
  logic          rd_valid_q;

  logic          push_req, push_ok, pop, full, empty, busy, bit_done;
  logic [3:0]    cnt_field;
  logic [31:0]   status_word;
  logic          unused_wr_hi;

  assign push_req  = wr_en && (wr_addr == OFF_DATA);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign pop       = (state_q == S_IDLE) && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push_req && (!full || pop);
  assign busy      = !empty || (state_q != S_IDLE);
  assign bit_done  = (bcnt_q == div_l_q);
  assign cnt_field = (32'(count_q) > 32'd15) ? 4'd15 : 4'(count_q);

  assign status_word  = {24'b0, cnt_field, overflow_q, empty, full, busy};
  assign unused_wr_hi = ^wr_data[31:16];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q] <= wr_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      div_q      <= DIV_DEFAULT;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (push_ok && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
      if (wr_en && (wr_addr == OFF_STATUS) && wr_data[3]) begin
        overflow_q <= 1'b0;
      end
      if (push_req && !push_ok) begin
        overflow_q <= 1'b1;
      end
      if (wr_en && (wr_addr == OFF_DIV)) begin
        div_q <= wr_data[15:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    tx_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_START;
          bcnt_d  = '0;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          state_d = S_DATA;
          bcnt_d  = '0;
          bidx_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 16'd1;
        end
      end
      S_DATA: begin
        tx_d = shift_q[bidx_q];
        if (bit_done) begin
          bcnt_d = '0;
          if (bidx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end else begin
          bcnt_d = bcnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          state_d = S_IDLE;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx is the registered image of the current state, so it trails the FSM by one clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      div_l_q <= DIV_DEFAULT;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      tx_q    <= tx_d;
      if (pop) begin
        shift_q <= mem[rptr_q];
        div_l_q <= div_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (rd_en) begin
        case (rd_addr)
          OFF_DATA: begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b1;
          end
          OFF_STATUS: begin
            rd_data_q  <= status_word;
            rd_valid_q <= 1'b1;
          end
          OFF_DIV: begin
            rd_data_q  <= {16'b0, div_q};
            rd_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - self-checking bench for uart_tx_periph
module tb_uart_tx_periph;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        tx;

  int          n_vec = 0;
  int          n_err = 0;
  int          model_div = 103;
  logic [7:0]  exp_q[$];

  uart_tx_periph #(
    .FIFO_DEPTH (8),
    .DIV_DEFAULT(16'd103)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic v);
    rd_en   = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_en   = 1'b0;
    d       = rd_data;
    v       = rd_valid;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    bus_read(a, d, v);
    chk({tag, "_valid"}, v, 1'b1);
    chk(tag, d, exp);
  endtask

  task automatic set_div(input int d);
    bus_write(16'h8, 32'(d));
    model_div = d;
  endtask

  task automatic send(input logic [7:0] b);
    exp_q.push_back(b);
    bus_write(16'h0, {24'b0, b});
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] d;
    logic        v;
    bit          done;
    done = 1'b0;
    d    = '0;
    for (int i = 0; i < 3000 && !done; i++) begin
      bus_read(16'h4, d, v);
      if (v && !d[0]) done = 1'b1;
    end
    chk({tag, "_idle"}, done, 1'b1);
    repeat (4) @(negedge clk);
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_status"}, d, 32'h4);
  endtask

  // Receiver: on a start bit, every clock of the 10-bit frame must hold its bit value.
  always begin : rx_mon
    int         d;
    int         bad;
    bit         aborted;
    logic [7:0] b;
    @(negedge clk);
    if (rst_n === 1'b1 && tx === 1'b0) begin
      d       = model_div;
      bad     = 0;
      aborted = 1'b0;
      b       = '0;
      for (int k = 0; k < 10 && !aborted; k++) begin
        for (int s = 0; s <= d && !aborted; s++) begin
          if (k != 0 || s != 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
          end else begin
            if (k >= 1 && k <= 8 && s == 0) b[k-1] = tx;
            if (k == 0 && tx !== 1'b0) bad++;
            else if (k == 9 && tx !== 1'b1) bad++;
            else if (k >= 1 && k <= 8 && tx !== b[k-1]) bad++;
          end
        end
      end
      if (!aborted) begin
        chk("frame_shape", bad, 0);
        if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
        else chk("frame_byte", b, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        v;
    int          bad;
    int          zeros;
    logic [7:0]  b;
    logic [9:0]  fr;

    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_rd_data", rd_data, 32'h0);
    rst_n = 1'b1;

    read_chk("reset_status", 16'h4, 32'h4);
    @(negedge clk);
    chk("rd_valid_one_cycle", rd_valid, 1'b0);
    read_chk("reset_div", 16'h8, 32'h67);
    read_chk("data_reads_zero", 16'h0, 32'h0);
    chk("idle_tx", tx, 1'b1);

    // Single frame, DIV=3: start bit two edges after the write.
    set_div(3);
    send(8'hA5);
    fr = {1'b1, 8'hA5, 1'b0};
    fork
      begin
        @(negedge clk);
        chk("a5_pre_start", tx, 1'b1);
        bad = 0;
        for (int k = 0; k < 10; k++)
          for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            if (tx !== fr[k]) bad++;
          end
        chk("a5_waveform", bad, 0);
      end
      begin
        repeat (10) @(negedge clk);
        read_chk("busy_mid_frame", 16'h4, 32'h5);
      end
    join
    read_chk("idle_after_frame", 16'h4, 32'h4);

    // Burst of 10 at DIV=0: nine fit, the tenth overflows.
    set_div(0);
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      if (i < 9) exp_q.push_back(b);
      bus_write(16'h0, {24'b0, b});
    end
    read_chk("overflow_status", 16'h4, 32'h8B);
    bus_write(16'h4, 32'h8);
    bus_read(16'h4, d, v);
    chk("overflow_cleared", d[3], 1'b0);
    wait_idle("burst");

    // Unmapped accesses and simultaneous read/write.
    set_div(2);
    read_chk("div_readback", 16'h8, 32'h2);
    rd_en = 1'b1; rd_addr = 16'hC;
    @(negedge clk);
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("unmapped_rd_valid", rd_valid, 1'b0);
      chk("unmapped_rd_data", rd_data, 32'h2);
      @(negedge clk);
    end
    bus_write(16'hC, 32'hFFFF_FFFF);
    read_chk("div_after_unmapped_wr", 16'h8, 32'h2);
    read_chk("status_after_unmapped_wr", 16'h4, 32'h4);
    rd_en = 1'b1; rd_addr = 16'h8;
    wr_en = 1'b1; wr_addr = 16'h8; wr_data = 32'h6;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    model_div = 6;
    chk("rw_same_cycle_old", rd_data, 32'h2);
    read_chk("rw_same_cycle_new", 16'h8, 32'h6);

    // DIV change mid-frame applies only to the next frame.
    set_div(3);
    send(8'h5A);
    send(8'hC3);
    repeat (8) @(negedge clk);
    set_div(7);
    wait_idle("div_change");

    for (int it = 0; it < 6; it++) begin
      int         n;
      logic [7:0] rb;
      set_div(int'($urandom_range(0, 5)));
      n = int'($urandom_range(1, 8));
      for (int j = 0; j < n; j++) begin
        rb = 8'($urandom);
        send(rb);
      end
      wait_idle("random");
    end

    // Reset during data bit 3 of the first of three queued frames.
    set_div(3);
    send(8'hC3);
    send(8'h3C);
    send(8'h99);
    repeat (16) @(negedge clk);
    chk("bit3_before_reset", tx, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("tx_after_reset", tx, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    model_div = 103;
    read_chk("status_after_reset", 16'h4, 32'h4);
    read_chk("div_after_reset", 16'h8, 32'h67);
    zeros = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
    end
    chk("no_frames_after_reset", zeros, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
